// File: rtl/dmem_responder.sv
// Single-ported data memory responder: accepts one request at a time, waits a
// fixed number of cycles, then answers with a one-cycle response strobe.
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_next;
   logic [3:0]  count, count_next;

   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rdata_q;
   logic        err_q;

   logic        handshake;
   logic        enter_resp;
   logic        cur_we;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic [3:0]  cur_be;
   logic        addr_err;
   logic [AW-1:0] index;

   assign handshake = req_valid && (state == IDLE);
   assign enter_resp = (state_next == RESP) && (state != RESP);

   // With zero wait states the commit happens on the handshake edge itself,
   // before the capture registers hold the request, so use the live inputs then.
   assign cur_we    = (state == IDLE) ? req_we    : we_q;
   assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
   assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
   assign cur_be    = (state == IDLE) ? req_be    : be_q;

   assign index    = cur_addr[AW+1:2];
   assign addr_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:AW+2] != '0);

   assign rsp_valid = (state == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   always_comb begin
      state_next = state;
      count_next = count;
      req_ready  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  state_next = RESP;
               end else begin
                  state_next = WAIT;
                  count_next = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         WAIT: begin
            if (count == 4'd0) begin
               state_next = RESP;
            end else begin
               count_next = count - 4'd1;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Response data is only ever nonzero during the single RESP cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         count   <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state <= state_next;
         count <= count_next;
         if (handshake) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
         end
         if (enter_resp) begin
            err_q   <= addr_err;
            rdata_q <= (addr_err || cur_we) ? 32'd0 : mem[index];
         end else begin
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
         end
      end
   end

   // Memory contents survive reset; a reset edge simply suppresses the commit.
   always_ff @(posedge clk) begin
      if (!reset && enter_resp && cur_we && !addr_err) begin
         for (int b = 0; b < 4; b++) begin
            if (cur_be[b]) begin
               mem[index][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule
